button_shaper_router: RTL and testbench
=======================================

Name: button_shaper_router

Overview:
- Parametrised successor to the fixed 3-button shaper plus 3-way decoder in the game top level.
- Synchronises and debounces NUM_BTNS raw push buttons, and emits one single-cycle press pulse per debounced press.
- Routes each pulse to one of NUM_DEST consumers (process control, game, scoreboard, ...) selected by process control.
- Destination is latched at pulse time, so a select change never splits or duplicates a press.

Parameters:
- NUM_BTNS, 3, number of push-button channels.
- NUM_DEST, 3, number of consumer ports.
- SEL_W, 2, width of dest_sel; must satisfy 2**SEL_W >= NUM_DEST.
- DEBOUNCE_CYCLES, 250000, consecutive stable synced cycles needed to accept a level change (minimum 2).
- BTN_ACTIVE_LOW, 1, 1 means raw inputs read 0 when pressed (DE2 KEY).
- HOLD_CYCLES, 25000000, held time before auto-repeat starts (optional feature only).
- REPEAT_CYCLES, 5000000, auto-repeat period (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  NUM_BTNS  raw asynchronous button pins.
- dest_sel  in  SEL_W  consumer index for the next pulses.
- btn_level  out  NUM_BTNS  debounced level, 1 = pressed.
- btn_pulse  out  NUM_DEST*NUM_BTNS  bit d*NUM_BTNS+b is the press pulse of button b to consumer d.
- drop_strobe  out  1  one-cycle flag: a pulse was discarded because dest_sel >= NUM_DEST.

Behaviour:
- Reset (rst=0, asynchronous):
  - All sync flops go to the not-pressed level.
  - All FSMs go to IDLE and all counters to 0.
  - btn_level, btn_pulse and drop_strobe go to 0.
- Synchronisation: each channel uses a 2-flop synchroniser. The input is inverted after syncing when BTN_ACTIVE_LOW=1. Call the result s.
- Per-channel FSM, states IDLE, PRESS_DB, HELD, RELEASE_DB:
  - IDLE: s=1 -> PRESS_DB with cnt=1.
  - PRESS_DB: s=0 -> IDLE with cnt=0. Otherwise cnt++.
  - PRESS_DB, when cnt reaches DEBOUNCE_CYCLES -> HELD. The registered pulse is asserted on the next cycle for exactly 1 cycle.
  - HELD: s=0 -> RELEASE_DB with cnt=1.
  - RELEASE_DB: s=1 -> HELD with cnt=0 and no new pulse. Otherwise when cnt reaches DEBOUNCE_CYCLES -> IDLE.
- btn_level is 1 in HELD and RELEASE_DB, 0 otherwise.
- Latency: raw press stable from clock edge k gives:
  - s=1 at k+2;
  - btn_pulse high only during cycle k+2+DEBOUNCE_CYCLES;
  - btn_level rises in the same cycle as the pulse.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1). It saturates and never wraps.
- Routing:
  - dest_sel is sampled in the cycle the FSM enters HELD. That value steers this pulse.
  - If the sampled dest_sel >= NUM_DEST, no btn_pulse bit is set and drop_strobe is 1 for that cycle.
- Simultaneous events:
  - Channels are independent. Several buttons may pulse in the same cycle, to the same or different consumers.
  - drop_strobe is the OR over channels.
- A dest_sel change while a button is HELD has no effect on that press.
- Reset released with a button held: the press is treated as new and pulses after the normal latency.
- At most one pulse per debounced press without the optional feature.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - After HOLD_CYCLES continuous cycles in HELD (counted from HELD entry), the channel emits a further pulse.
  - It then emits one every REPEAT_CYCLES while still HELD.
  - Each repeat pulse re-samples dest_sel at its own cycle, with the same drop rule.
  - Entering RELEASE_DB freezes the repeat timer. Returning to HELD from a bounce resumes it without a pulse. Reaching IDLE clears it.
- Undefined: no repeat counter is built, and HOLD_CYCLES/REPEAT_CYCLES are unused.

Decomposition:
- Package bits_please_pkg holds:
  - the btn_state_t enum (IDLE, PRESS_DB, HELD, RELEASE_DB);
  - a clog2/max helper function;
  - consumer index constants DEST_PROC=0, DEST_GAME=1, DEST_SCORE=2.
- Sub-module button_debounce_channel, one per button via generate. It contains the synchroniser, FSM, counter, level/pulse outputs and optional repeat logic.
- The top level does dest_sel sampling, fan-out and drop_strobe.

Test Plan:
(All use DEBOUNCE_CYCLES=4, NUM_BTNS=3, NUM_DEST=3, BTN_ACTIVE_LOW=1.)
- Clean press: btn_raw[0] drops at edge 10 and stays low, dest_sel=1 -> btn_pulse[1*3+0] high only in cycle 16, btn_level[0]=1 from cycle 16, all other bits 0.
- Bounce: btn_raw[1] toggles low/high every 2 cycles for 20 cycles, then stays low -> exactly one pulse, 6 cycles after the final stable-low edge.
- Select change mid-hold: press btn 2 with dest_sel=0, switch dest_sel to 2 while held, release -> one pulse on bit 2 only, and none on bit 8.
- Invalid select: dest_sel=3, press btn 0 -> btn_pulse stays all-0 and drop_strobe=1 for exactly one cycle.
- Simultaneous plus reset: buttons 0 and 2 pressed together with dest_sel=2 -> bits 6 and 8 pulse in the same cycle. Assert rst=0 mid-hold -> all outputs 0 immediately. Release rst while still held -> new pulses 6 cycles later.
- Auto-repeat (macro defined, HOLD_CYCLES=20, REPEAT_CYCLES=8): hold btn 1 for 50 cycles -> pulses at entry, entry+20, entry+28, entry+36, entry+44, and none after release.

Source files
------------

// File: rtl/bits_please_pkg.sv
// rtl/bits_please_pkg.sv - shared types, counter sizing helper and consumer indices for button_shaper_router
package bits_please_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } btn_state_t;

    localparam int DEST_PROC  = 0;
    localparam int DEST_GAME  = 1;
    localparam int DEST_SCORE = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold any of the three terminal counts without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c) + 1);
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - one button: synchroniser, debounce FSM, press pulse; auto-repeat under BUTTON_AUTO_REPEAT_EN
module button_debounce_channel
    import bits_please_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic fire,
    output logic pulse
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic          RAW_IDLE = BTN_ACTIVE_LOW;

    logic [1:0]    sync_q;
    logic          s;
    btn_state_t    state_q;
    btn_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          pulse_q;
    logic          press_accept;
    logic          rpt_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {2{RAW_IDLE}};
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // s is 1 while pressed regardless of pin polarity.
    assign s       = sync_q[1] ^ RAW_IDLE;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= fire;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_DB;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_DB: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_DB: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_accept = (state_q == PRESS_DB) && (state_d == HELD);
        level        = (state_q == HELD) || (state_q == RELEASE_DB);
        fire         = press_accept || rpt_hit;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES);

    logic [CW-1:0] rcnt_q;
    logic          rep_phase_q;

    // rcnt only advances in HELD, so a release bounce freezes the timer in place.
    assign rpt_hit = (state_q == HELD) && (rcnt_q == (rep_phase_q ? REP_TC : HOLD_TC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q      <= '0;
            rep_phase_q <= 1'b0;
        end else if (press_accept) begin
            rcnt_q      <= CW'(1);
            rep_phase_q <= 1'b0;
        end else if (state_d == IDLE) begin
            rcnt_q      <= '0;
            rep_phase_q <= 1'b0;
        end else if (state_q == HELD) begin
            if (rpt_hit) begin
                rcnt_q      <= CW'(1);
                rep_phase_q <= 1'b1;
            end else if (rcnt_q != CNT_MAX) begin
                rcnt_q <= rcnt_q + 1'b1;
            end
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    assign pulse = pulse_q;

endmodule

// File: rtl/button_shaper_router.sv
// rtl/button_shaper_router.sv - debounced button pulses routed to a consumer latched at pulse time; BUTTON_AUTO_REPEAT_EN adds auto-repeat
module button_shaper_router
    import bits_please_pkg::*;
#(
    parameter int NUM_BTNS        = 3,
    parameter int NUM_DEST        = 3,
    parameter int SEL_W           = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BTNS-1:0]          btn_raw,
    input  logic [SEL_W-1:0]             dest_sel,
    output logic [NUM_BTNS-1:0]          btn_level,
    output logic [NUM_DEST*NUM_BTNS-1:0] btn_pulse,
    output logic                         drop_strobe
);

    localparam logic [SEL_W:0] DEST_LIMIT = (SEL_W+1)'(NUM_DEST);

    logic [NUM_BTNS-1:0]            fire;
    logic [NUM_BTNS-1:0]            pulse;
    logic [NUM_BTNS-1:0]            sel_bad;
    logic [NUM_BTNS-1:0][SEL_W-1:0] sel_q;

    // Destination is captured on the same edge that registers the pulse,
    // so a later dest_sel change cannot move or duplicate it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BTNS; b++) begin
                if (fire[b]) begin
                    sel_q[b] <= dest_sel;
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[b]),
            .level   (btn_level[b]),
            .fire    (fire[b]),
            .pulse   (pulse[b])
        );

        assign sel_bad[b] = ({1'b0, sel_q[b]} >= DEST_LIMIT);

        for (genvar d = 0; d < NUM_DEST; d++) begin : g_dest
            assign btn_pulse[d*NUM_BTNS+b] = pulse[b] && (sel_q[b] == SEL_W'(d));
        end
    end

    assign drop_strobe = |(pulse & sel_bad);

endmodule

// File: tb/tb_button_shaper_router.sv
// tb/tb_button_shaper_router.sv - randomized and directed checks of button_shaper_router against a run-length reference model
module tb_button_shaper_router;
    import bits_please_pkg::*;

    localparam int NB   = 3;
    localparam int ND   = 3;
    localparam int SW   = 2;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NB-1:0]     btn_raw = '1;
    logic [SW-1:0]     dest_sel = '0;
    logic [NB-1:0]     btn_level;
    logic [ND*NB-1:0]  btn_pulse;
    logic              drop_strobe;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_shaper_router #(
        .NUM_BTNS        (NB),
        .NUM_DEST        (ND),
        .SEL_W           (SW),
        .DEBOUNCE_CYCLES (DB),
        .BTN_ACTIVE_LOW  (1'b1),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .dest_sel    (dest_sel),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .drop_strobe (drop_strobe)
    );

    // Reference: the level flips once the pressed value has disagreed with it for DB
    // consecutive cycles; a flip to pressed is a press. Repeats count cycles spent held.
    typedef struct packed {
        logic        lvl;
        logic        fire;
        int          run;
        int          hcnt;
    } mstep_t;

    logic [NB-1:0] m_d1, m_d2, m_lvl, m_pulse;
    int            m_run  [NB];
    int            m_hcnt [NB];
    logic [SW-1:0] m_sel  [NB];
    mstep_t        m_nx   [NB];

    function automatic mstep_t model_step(input logic s, input logic lvl, input int run, input int hcnt);
        mstep_t o;
`ifdef BUTTON_AUTO_REPEAT_EN
        logic held;
        held = lvl && (run == 0);
`endif
        o.lvl  = lvl;
        o.fire = 1'b0;
        o.hcnt = hcnt;
        o.run  = (s != lvl) ? run + 1 : 0;
        if (o.run == DB) begin
            o.lvl  = !lvl;
            o.run  = 0;
            o.hcnt = 0;
            o.fire = o.lvl;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        if (held) begin
            o.hcnt = hcnt + 1;
            if (o.hcnt == HOLD || (o.hcnt > HOLD && (o.hcnt - HOLD) % REP == 0)) o.fire = 1'b1;
        end
`endif
        return o;
    endfunction

    always_comb begin
        for (int b = 0; b < NB; b++) m_nx[b] = model_step(m_d2[b], m_lvl[b], m_run[b], m_hcnt[b]);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_d1 <= '0; m_d2 <= '0; m_lvl <= '0; m_pulse <= '0;
            for (int b = 0; b < NB; b++) begin
                m_run[b] <= 0; m_hcnt[b] <= 0; m_sel[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                m_lvl[b]   <= m_nx[b].lvl;
                m_run[b]   <= m_nx[b].run;
                m_hcnt[b]  <= m_nx[b].hcnt;
                m_pulse[b] <= m_nx[b].fire;
                if (m_nx[b].fire) m_sel[b] <= dest_sel;
                m_d2[b] <= m_d1[b];
                m_d1[b] <= ~btn_raw[b];
            end
        end
    end

    function automatic logic [ND*NB-1:0] exp_bp();
        logic [ND*NB-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++)
            if (m_pulse[b] && int'(m_sel[b]) < ND) v[int'(m_sel[b])*NB + b] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_drop();
        logic v;
        v = 1'b0;
        for (int b = 0; b < NB; b++) if (m_pulse[b] && int'(m_sel[b]) >= ND) v = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0; btn_raw = '1; dest_sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (btn_pulse !== '0) $display("FAIL reset_pulse: got %h want 0", btn_pulse); else n_pass++;
        n_checks++;
        if (btn_level !== '0) $display("FAIL reset_level: got %b want 0", btn_level); else n_pass++;
        n_checks++;
        if (drop_strobe !== 1'b0) $display("FAIL reset_drop: got %b want 0", drop_strobe); else n_pass++;
        @(posedge clk); #1; rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if ({btn_pulse, btn_level, drop_strobe} !== {exp_bp(), m_lvl, exp_drop()})
                $display("FAIL reset_model cyc %0d: got %h/%b/%b want %h/%b/%b", cyc, btn_pulse, btn_level, drop_strobe, exp_bp(), m_lvl, exp_drop());
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        int k;
        @(posedge clk); #1;
        dest_sel = 2'd1; btn_raw[0] = 1'b0; k = cyc;
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if (btn_pulse !== ((cyc == k + 2 + DB) ? 9'h008 : 9'h000))
                $display("FAIL clean_pulse cyc %0d: got %h want %h", cyc - k, btn_pulse, (cyc == k + 2 + DB) ? 9'h008 : 9'h000);
            else n_pass++;
            n_checks++;
            if (btn_level !== ((cyc >= k + 2 + DB) ? 3'b001 : 3'b000))
                $display("FAIL clean_level cyc %0d: got %b", cyc - k, btn_level);
            else n_pass++;
        end
        btn_raw[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if ({btn_pulse, btn_level, drop_strobe} !== {exp_bp(), m_lvl, exp_drop()})
                $display("FAIL clean_model cyc %0d: got %h/%b/%b want %h/%b/%b", cyc, btn_pulse, btn_level, drop_strobe, exp_bp(), m_lvl, exp_drop());
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int kf;
        int got[$];
        dest_sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            repeat (2) begin
                @(posedge clk); #1;
                btn_raw[1] = i[0];
                if (btn_pulse[1]) got.push_back(cyc);
            end
        end
        @(posedge clk); #1;
        btn_raw[1] = 1'b0; kf = cyc;
        repeat (12) begin
            @(negedge clk);
            if (btn_pulse[1]) got.push_back(cyc);
        end
        n_checks++;
        if (got.size() !== 1) $display("FAIL bounce_count: got %0d pulses want 1", got.size()); else n_pass++;
        n_checks++;
        if (got.size() > 0 && got[0] !== kf + 2 + DB)
            $display("FAIL bounce_time: got +%0d want +%0d", got[0] - kf, 2 + DB);
        else n_pass++;
        btn_raw[1] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_select_change();
        int k, n2, n8;
        n2 = 0; n8 = 0;
        @(posedge clk); #1;
        dest_sel = 2'd0; btn_raw[2] = 1'b0; k = cyc;
        repeat (14) begin
            @(negedge clk);
            if (cyc == k + 9) dest_sel = 2'd2;
            n2 += int'(btn_pulse[2]); n8 += int'(btn_pulse[8]);
        end
        btn_raw[2] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n2 += int'(btn_pulse[2]); n8 += int'(btn_pulse[8]);
            n_checks++;
            if ({btn_pulse, btn_level, drop_strobe} !== {exp_bp(), m_lvl, exp_drop()})
                $display("FAIL selchg_model cyc %0d: got %h/%b/%b want %h/%b/%b", cyc, btn_pulse, btn_level, drop_strobe, exp_bp(), m_lvl, exp_drop());
            else n_pass++;
        end
        n_checks++;
        if (n2 !== 1) $display("FAIL selchg_bit2: got %0d pulses want 1", n2); else n_pass++;
        n_checks++;
        if (n8 !== 0) $display("FAIL selchg_bit8: got %0d pulses want 0", n8); else n_pass++;
    endtask

    task automatic test_invalid_select();
        int k, nd, nbad;
        nd = 0; nbad = 0;
        @(posedge clk); #1;
        dest_sel = 2'd3; btn_raw[0] = 1'b0; k = cyc;
        repeat (12) begin
            @(negedge clk);
            if (btn_pulse !== '0) nbad++;
            if (drop_strobe) begin
                nd++;
                n_checks++;
                if (cyc !== k + 2 + DB) $display("FAIL invalid_drop_time: got +%0d want +%0d", cyc - k, 2 + DB); else n_pass++;
            end
        end
        n_checks++;
        if (nd !== 1) $display("FAIL invalid_drop_count: got %0d want 1", nd); else n_pass++;
        n_checks++;
        if (nbad !== 0) $display("FAIL invalid_pulse: got %0d nonzero cycles want 0", nbad); else n_pass++;
        btn_raw[0] = 1'b1; dest_sel = 2'd0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_simul_reset();
        int k;
        @(posedge clk); #1;
        dest_sel = 2'd2; btn_raw[0] = 1'b0; btn_raw[2] = 1'b0; k = cyc;
        repeat (9) begin
            @(negedge clk);
            n_checks++;
            if (btn_pulse !== ((cyc == k + 2 + DB) ? 9'h140 : 9'h000))
                $display("FAIL simul_pulse cyc +%0d: got %h", cyc - k, btn_pulse);
            else n_pass++;
        end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({btn_pulse, btn_level, drop_strobe} !== '0)
            $display("FAIL async_reset: got %h/%b/%b want all 0", btn_pulse, btn_level, drop_strobe);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; k = cyc;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (btn_pulse !== ((cyc == k + 2 + DB) ? 9'h140 : 9'h000))
                $display("FAIL rerelease_pulse cyc +%0d: got %h", cyc - k, btn_pulse);
            else n_pass++;
        end
        btn_raw = '1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_hold();
        int k;
        int got[$];
        int want[$];
        @(posedge clk); #1;
        dest_sel = 2'd1; btn_raw[1] = 1'b0; k = cyc;
        want.push_back(k + 2 + DB);
`ifdef BUTTON_AUTO_REPEAT_EN
        for (int t = k + 2 + DB + HOLD; t <= k + 2 + DB + 44; t += REP) want.push_back(t);
`endif
        repeat (50) begin
            @(negedge clk);
            if (btn_pulse[4]) got.push_back(cyc);
        end
        btn_raw[1] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (btn_pulse[4]) got.push_back(cyc);
        end
        n_checks++;
        if (got.size() !== want.size()) $display("FAIL hold_count: got %0d pulses want %0d", got.size(), want.size()); else n_pass++;
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== want[i]) $display("FAIL hold_time[%0d]: got +%0d want +%0d", i, got[i] - k, want[i] - k); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            for (int b = 0; b < NB; b++) if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(3) == 0) dest_sel = SW'($urandom_range(3));
            @(negedge clk);
            n_checks++;
            if ({btn_pulse, btn_level, drop_strobe} !== {exp_bp(), m_lvl, exp_drop()})
                $display("FAIL random_model cyc %0d: got %h/%b/%b want %h/%b/%b", cyc, btn_pulse, btn_level, drop_strobe, exp_bp(), m_lvl, exp_drop());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_select_change();
        test_invalid_select();
        test_simul_reset();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
